// File: rtl/dmem_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: access-size codes,
// default widths and depth, and small funct3 helpers.
// Build option: STORE_FWD_EN (see dmem_store_buffer.sv).
package dmem_store_buffer_pkg;

  // Default address/data widths and store-buffer depth
  localparam int ADDR_SIZE = 32;
  localparam int WORD_LEN  = 32;
  localparam int SB_DEPTH  = 4;

  // RISC-V funct3 access-size encodings
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Who owns the memory port in a given cycle
  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_DRAIN = 2'd2
  } port_sel_e;

  // Full-word access (load or store share the same code)
  function automatic logic f3_is_word(input logic [2:0] f3);
    return (f3 == FUNCT3_LW) || (f3 == FUNCT3_SW);
  endfunction

  // Legal load encodings
  function automatic logic f3_is_load(input logic [2:0] f3);
    return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
           (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
  endfunction

  // Legal store encodings
  function automatic logic f3_is_store(input logic [2:0] f3);
    return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Word-address match of an incoming request against occupied buffer entries.
// Latency: combinational.
// Backpressure: none; the caller decides whether a hazard stalls.
module store_buffer_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-3:0] req_word_i,
  input  logic [ADDR_W-3:0] ent_word_i [DEPTH],
  input  logic [DEPTH-1:0]  ent_vld_i,
  input  logic [PTR_W-1:0]  tail_i,
  output logic              hazard_o,
  output logic [PTR_W-1:0]  newest_idx_o
);

  logic [PTR_W-1:0] idx;

  // Walk entries oldest to newest (distance from tail shrinking) so the
  // last hit recorded is the youngest matching store.
  always_comb begin
    hazard_o     = 1'b0;
    newest_idx_o = '0;
    idx          = '0;
    for (int d = DEPTH; d >= 1; d--) begin
      idx = tail_i - PTR_W'(d);
      if (ent_vld_i[idx] && (ent_word_i[idx] == req_word_i)) begin
        hazard_o     = 1'b1;
        newest_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer owning the data-memory port: queues stores, drains one per free cycle.
// Latency: loads zero-cycle (combinational read-back); stores reach memory >= 1 edge after enqueue.
// Backpressure: reqReady drops when full, on fence, or when a load hits a pending store's word.
// Build option: define STORE_FWD_EN to forward word loads from an identical buffered word store.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = WORD_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reqValid,
  input  logic                   reqWrite,
  input  logic [ADDR_W-1:0]      reqAddr,
  input  logic [2:0]             reqFunct3,
  input  logic [DATA_W-1:0]      reqWData,
  output logic                   reqReady,
  output logic                   loadValid,
  output logic [DATA_W-1:0]      loadData,
  input  logic                   fence,
  output logic                   bufEmpty,
  output logic [$clog2(DEPTH):0] bufCount,
  output logic                   dmemWriteEnable,
  output logic [ADDR_W-1:0]      dmemAddr,
  output logic [2:0]             dmemUnitSize,
  output logic [DATA_W-1:0]      dmemWriteData,
  input  logic [DATA_W-1:0]      dmemReadData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [2:0]        f3_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0]  occ;
  logic [PTR_W-1:0]  rel;
  logic [ADDR_W-3:0] ent_word [DEPTH];
  logic              hazard;
  logic [PTR_W-1:0]  newest_idx;

  logic      full;
  logic      blocked;
  logic      st_acc;
  logic      ld_grant;
  logic      ld_fwd;
  logic      drain;
  port_sel_e port_sel;

  // An entry is occupied when its distance from head is below count
  always_comb begin
    occ = '0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel      = PTR_W'(i) - head_q;
      occ[i]   = ({1'b0, rel} < count_q);
      ent_word[i] = addr_q[i][ADDR_W-1:2];
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .req_word_i   (reqAddr[ADDR_W-1:2]),
    .ent_word_i   (ent_word),
    .ent_vld_i    (occ),
    .tail_i       (tail_q),
    .hazard_o     (hazard),
    .newest_idx_o (newest_idx)
  );

  // Request arbitration: a full buffer or fence takes the port away from loads
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    blocked  = full | fence;
    st_acc   = reqValid & reqWrite & ~blocked;
    ld_grant = reqValid & ~reqWrite & ~hazard & ~blocked;
`ifdef STORE_FWD_EN
    ld_fwd   = reqValid & ~reqWrite & hazard & ~blocked &
               f3_is_word(reqFunct3) & f3_is_word(f3_q[newest_idx]) &
               (addr_q[newest_idx] == reqAddr);
`else
    ld_fwd   = 1'b0;
`endif
    if (ld_grant) begin
      port_sel = PORT_LOAD;
    end else if (count_q != '0) begin
      port_sel = PORT_DRAIN;
    end else begin
      port_sel = PORT_IDLE;
    end
    drain = (port_sel == PORT_DRAIN);
  end

  // Memory port and request-side outputs; idle port drives zeros
  always_comb begin
    dmemWriteEnable = 1'b0;
    dmemAddr        = '0;
    dmemUnitSize    = '0;
    dmemWriteData   = '0;
    unique case (port_sel)
      PORT_LOAD: begin
        dmemAddr     = reqAddr;
        dmemUnitSize = reqFunct3;
      end
      PORT_DRAIN: begin
        dmemWriteEnable = 1'b1;
        dmemAddr        = addr_q[head_q];
        dmemUnitSize    = f3_q[head_q];
        dmemWriteData   = data_q[head_q];
      end
      default: begin
        dmemWriteEnable = 1'b0;
      end
    endcase
    reqReady  = st_acc | ld_grant | ld_fwd;
    loadValid = ld_grant | ld_fwd;
    if (ld_fwd) begin
      loadData = data_q[newest_idx];
    end else if (ld_grant) begin
      loadData = dmemReadData;
    end else begin
      loadData = '0;
    end
    bufEmpty = (count_q == '0);
    bufCount = count_q;
  end

  // Next-state for pointers and occupancy count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d = head_q + PTR_W'(1);
    end
    if (st_acc) begin
      tail_d = tail_q + PTR_W'(1);
    end
    unique case ({st_acc, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset discards any pending stores
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload write at the tail; contents are qualified by count, so no reset
  always_ff @(posedge clk) begin
    if (st_acc) begin
      addr_q[tail_q] <= reqAddr;
      f3_q[tail_q]   <= reqFunct3;
      data_q[tail_q] <= reqWData;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized and directed bench for dmem_store_buffer against a queue-based model.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqWrite, fence;
  logic [31:0] reqAddr, reqWData;
  logic [2:0]  reqFunct3;
  logic        reqReady, loadValid, bufEmpty, dmemWriteEnable;
  logic [31:0] loadData, dmemAddr, dmemWriteData, dmemReadData;
  logic [2:0]  bufCount, dmemUnitSize;

  always #5 clk = ~clk;

  dmem_store_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .reqValid        (reqValid),
    .reqWrite        (reqWrite),
    .reqAddr         (reqAddr),
    .reqFunct3       (reqFunct3),
    .reqWData        (reqWData),
    .reqReady        (reqReady),
    .loadValid       (loadValid),
    .loadData        (loadData),
    .fence           (fence),
    .bufEmpty        (bufEmpty),
    .bufCount        (bufCount),
    .dmemWriteEnable (dmemWriteEnable),
    .dmemAddr        (dmemAddr),
    .dmemUnitSize    (dmemUnitSize),
    .dmemWriteData   (dmemWriteData),
    .dmemReadData    (dmemReadData)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Memory semantics: sized/extended read and byte-lane merge on write
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                       input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Environment memory seen by the DUT
  logic [31:0] tb_mem  [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};

  assign dmemReadData = ext(tb_mem[dmemAddr[9:2]], dmemAddr[1:0], dmemUnitSize);

  always @(posedge clk) begin
    if (dmemWriteEnable)
      tb_mem[dmemAddr[9:2]] <= merge(tb_mem[dmemAddr[9:2]], dmemAddr[1:0], dmemUnitSize, dmemWriteData);
  end

  // Reference model: pending stores in program order, oldest at the front
  typedef struct {
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] d;
  } st_t;
  st_t q[$];
  logic [31:0] last_ld;

  task automatic cyc(input logic v, input logic wr, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] d, input logic fn);
    bit haz, full, grant, fwd, st, drain;
    int ni;
    st_t e;
    logic [31:0] exp_ld;
    @(negedge clk);
    reqValid = v; reqWrite = wr; reqAddr = a; reqFunct3 = f3; reqWData = d; fence = fn;
    #1;
    haz = 0; fwd = 0; ni = -1;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) begin haz = 1; ni = i; end
    full  = (q.size() == 4);
    grant = v && !wr && !haz && !full && !fn;
    st    = v && wr && !full && !fn;
`ifdef STORE_FWD_EN
    if (v && !wr && haz && !full && !fn && f3 == 3'b010 && q[ni].f == 3'b010 && q[ni].a == a)
      fwd = 1;
`endif
    drain = (q.size() > 0) && !grant;
    exp_ld = 32'h0;
    if (grant) exp_ld = ext(ref_mem[a[9:2]], a[1:0], f3);
    else if (fwd) exp_ld = q[ni].d;
    chk("reqReady", reqReady, st | grant | fwd);
    chk("loadValid", loadValid, grant | fwd);
    chk("loadData", loadData, exp_ld);
    chk("dmemWriteEnable", dmemWriteEnable, drain);
    if (drain) begin
      chk("drainAddr", dmemAddr, q[0].a);
      chk("drainSize", dmemUnitSize, q[0].f);
      chk("drainData", dmemWriteData, q[0].d);
    end else if (grant) begin
      chk("loadAddr", dmemAddr, a);
      chk("loadSize", dmemUnitSize, f3);
      chk("loadWData", dmemWriteData, 32'h0);
    end else begin
      chk("idleAddr", dmemAddr, 32'h0);
      chk("idleSize", dmemUnitSize, 3'h0);
      chk("idleWData", dmemWriteData, 32'h0);
    end
    chk("bufCount", bufCount, q.size());
    chk("bufEmpty", bufEmpty, q.size() == 0);
    if (grant || fwd) last_ld = loadData;
    if (drain) begin
      e = q.pop_front();
      ref_mem[e.a[9:2]] = merge(ref_mem[e.a[9:2]], e.a[1:0], e.f, e.d);
    end
    if (st) q.push_back('{a, f3, d});
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 3'h0, 32'h0, 1'b0);
  endtask

  logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] sd_f3 [3] = '{3'b000, 3'b001, 3'b010};

  initial begin
    rst = 1'b1;
    reqValid = 0; reqWrite = 0; reqAddr = 0; reqFunct3 = 0; reqWData = 0; fence = 0;
    last_ld = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bufEmpty", bufEmpty, 1'b1);
    chk("rst_bufCount", bufCount, 3'd0);
    chk("rst_we", dmemWriteEnable, 1'b0);
    chk("rst_loadValid", loadValid, 1'b0);
    chk("rst_addr", dmemAddr, 32'h0);
    chk("rst_wdata", dmemWriteData, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Store word then idle: written the next cycle, buffer empty afterwards
    cyc(1, 1, 32'h100, 3'b010, 32'hDEADBEEF, 0);
    idle();
    idle();
    chk("t1_mem", tb_mem[8'h40], 32'hDEADBEEF);

    // Byte store, then word load of the same word stalls once, then sees the byte
    cyc(1, 1, 32'h203, 3'b000, 32'h7F, 0);
    cyc(1, 0, 32'h200, 3'b010, 32'h0, 0);
    cyc(1, 0, 32'h200, 3'b010, 32'h0, 0);
    chk("t3_byte", {24'h0, last_ld[31:24]}, 32'h7F);

    // Unrelated load is granted immediately, drain deferred one cycle
    cyc(1, 1, 32'h100, 3'b010, 32'hCAFEF00D, 0);
    cyc(1, 0, 32'h300, 3'b010, 32'h0, 0);
    idle();

    // Fence blocks a store and drains the pending one
    cyc(1, 1, 32'h108, 3'b001, 32'hBEEF, 0);
    cyc(1, 1, 32'h10C, 3'b010, 32'h1, 1);
    cyc(0, 0, 32'h0, 3'h0, 32'h0, 1);

    // Word store then word load at the same address; then a half load stalls
    cyc(1, 1, 32'h40, 3'b010, 32'h12345678, 0);
    cyc(1, 0, 32'h40, 3'b010, 32'h0, 0);
`ifdef STORE_FWD_EN
    chk("fwd_data", last_ld, 32'h12345678);
`endif
    cyc(1, 1, 32'h40, 3'b010, 32'hA5A5_5A5A, 0);
    cyc(1, 0, 32'h40, 3'b001, 32'h0, 0);
    cyc(1, 0, 32'h40, 3'b001, 32'h0, 0);

    // Reset asserted while a store is waiting to drain: discarded at once
    cyc(1, 1, 32'h104, 3'b010, 32'h55AA55AA, 0);
    @(negedge clk);
    reqValid = 0; fence = 0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_count", bufCount, 3'd0);
    chk("mid_rst_empty", bufEmpty, 1'b1);
    chk("mid_rst_we", dmemWriteEnable, 1'b0);
    q.delete();
    @(negedge clk);
    chk("mid_rst_mem", tb_mem[8'h41], ref_mem[8'h41]);
    rst = 1'b0;

    // Randomized traffic over a few words to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      logic        v, wr, fn;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] a;
      v  = ($urandom_range(3) != 0);
      wr = $urandom_range(1);
      fn = ($urandom_range(15) == 0);
      f3 = wr ? sd_f3[$urandom_range(2)] : ld_f3[$urandom_range(4)];
      case (f3[1:0])
        2'b00:   off = 2'($urandom_range(3));
        2'b01:   off = {1'($urandom_range(1)), 1'b0};
        default: off = 2'b00;
      endcase
      a = 32'h100 + 32'($urandom_range(7)) * 4 + {30'h0, off};
      cyc(v, wr, a, f3, $urandom, fn);
    end

    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits between the MEM stage and the data memory; owns the data memory's single address/write port.
- Stores are queued in a small FIFO and drained into memory one per cycle whenever no load needs the port.
- Loads go straight to memory with combinational read-back, but stall while an older buffered store targets the same word.
- Decouples store retirement from memory-port contention; a fence input forces a full drain.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
ADDR_W, 32, address width
DATA_W, 32, data word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
reqValid  in  1  MEM-stage memory request present
reqWrite  in  1  1 = store, 0 = load
reqAddr  in  ADDR_W  byte address
reqFunct3  in  3  access size/sign, RISC-V funct3 encoding
reqWData  in  DATA_W  store data, right-aligned
reqReady  out  1  request accepted this cycle
loadValid  out  1  loadData valid this cycle
loadData  out  DATA_W  load result, already sized and extended
fence  in  1  drain request; blocks all new requests until empty
bufEmpty  out  1  no pending stores
bufCount  out  log2(DEPTH)+1  number of occupied entries
dmemWriteEnable  out  1  memory write strobe
dmemAddr  out  ADDR_W  memory address
dmemUnitSize  out  3  funct3 passed to memory
dmemWriteData  out  DATA_W  memory write data
dmemReadData  in  DATA_W  memory combinational read data

Behaviour:
Reset:
- rst=1 asynchronously clears head, tail and count to 0.
- Pending stores are discarded, including on reset mid-drain.
- Outputs after reset: bufEmpty=1, bufCount=0, dmemWriteEnable=0, loadValid=0, all dmem buses 0.

Entries and pointers:
- Each entry holds {addr, funct3, data}.
- Head and tail wrap modulo DEPTH.
- count updates by +1 on enqueue, -1 on drain, and is unchanged when both occur in the same cycle.

Store path:
- reqReady = reqValid & reqWrite & count<DEPTH & !fence.
- The store enqueues at the tail on that edge.
- When full, a store is refused even if a drain happens in the same cycle; there is no pass-through.

Load path:
- hazard = any occupied entry with addr[ADDR_W-1:2] == reqAddr[ADDR_W-1:2].
- A load is granted when reqValid & !reqWrite & !hazard & count<DEPTH & !fence.
- On grant: dmemAddr=reqAddr, dmemUnitSize=reqFunct3, dmemWriteEnable=0, loadData=dmemReadData, loadValid=1, reqReady=1, all in the same cycle (zero latency).
- Otherwise the load is stalled: reqReady=0, loadValid=0.

Drain:
- Occurs when count>0 and the port was not granted to a load.
- Drives dmemWriteEnable=1 with the head entry's addr, funct3 and data; head pops on the edge.
- A full buffer gives the drain priority over loads, which bounds starvation.

Latency and idle:
- A store enqueued at edge N is at the head at N+1 at the earliest.
- It is written at edge N+1 when it is the only entry and no load was granted.
- With no load and count=0, all dmem outputs are 0.

Fence:
- While fence=1, reqReady=0 and the buffer drains unconditionally.
- bufEmpty=1 signals the drain is complete.

Optional Feature:
Macro STORE_FWD_EN.
- When defined: a hazarding load with reqFunct3=word is forwarded if the newest matching entry has funct3=word and an identical addr.
  - loadData comes from that entry's data; loadValid=1, reqReady=1.
  - The port remains free, so a drain proceeds in the same cycle.
  - Any other hazard still stalls.
- When undefined: every hazard stalls.

Decomposition:
- Shared defines file: the existing FUNCT3_* constants, the ADDR_SIZE/WORD_LEN widths, and a new SB_DEPTH default.
- One sub-module, store_buffer_match.
  - Compares reqAddr against all valid entries.
  - Returns the hazard flag and the newest-match index (age order relative to tail).

Test Plan:
1. Reset, then store word 0xDEADBEEF to 0x100 with no loads -> dmemWriteEnable=1 at addr 0x100 the next cycle; bufEmpty=1 after that edge.
2. Fill 4 stores back-to-back while a load stream holds the port -> 5th store sees reqReady=0; a full buffer blocks loads and one drain occurs.
3. Store byte 0x7F to 0x203, then load word from 0x200 -> stalled until that entry drains; then loadValid=1 with bits [31:24]=0x7F.
4. Load from 0x300 with an unrelated store pending at 0x100 -> loadValid the same cycle, drain deferred by one cycle.
5. Assert fence with 3 entries pending -> reqReady=0 for 3 cycles, then bufEmpty=1; assert rst mid-drain -> count=0 immediately.
6. With STORE_FWD_EN, store word 0x12345678 to 0x40, then load word 0x40 -> loadData=0x12345678 with no stall; a load half from 0x40 still stalls.
